// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: mul/div FSM state
// encoding, EXE forward-select codes, default multi-cycle latency and the
// register-match helper used by every hazard and forward check.
package pipe_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int MD_LAT_DEF = 8;
  localparam int MD_CNT_W   = $clog2(64);

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/md_timer.sv
// Loadable down-counter timing the BUSY phase of a multi-cycle EXE op.
// Holds at zero rather than wrapping.
module md_timer
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic [MD_CNT_W-1:0] cnt,
  output logic                zero
);

  // Counter register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline: load-use and branch
// operand stalls, taken-branch flush, EXE and ID forwarding, and an optional
// mul/div occupancy FSM enabled by the macro PIPE_MULDIV_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs_decode,
  input  logic [4:0] Rt_decode,
  input  logic [4:0] Rs_exe,
  input  logic [4:0] Rt_exe,
  input  logic [4:0] writereg_exe,
  input  logic [4:0] writereg_mem,
  input  logic [4:0] writereg_wb,
  input  logic       regwrite_exe,
  input  logic       regwrite_mem,
  input  logic       regwrite_wb,
  input  logic       memtoreg_exe,
  input  logic       memtoreg_mem,
  input  logic       branch_decode,
  input  logic       taken_decode,
  input  logic       mdstart_exe,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       stall_exe,
  output logic       flush_decode,
  output logic       flush_exe,
  output logic       flush_mem,
  output logic [1:0] forwardA_exe,
  output logic [1:0] forwardB_exe,
  output logic       forwardA_decode,
  output logic       forwardB_decode,
  output logic       md_busy,
  output logic       md_done
);

  logic md_stall;
  logic md_active;
  logic md_last;

`ifdef PIPE_MULDIV_EN
  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 2);

  md_state_e           state, state_nxt;
  logic                cnt_load, cnt_dec, cnt_zero;
  logic [MD_CNT_W-1:0] cnt;

  md_timer u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (MD_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Mul/div state register.
  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  // Next state: the IDLE cycle is the op's first EXE cycle, BUSY covers
  // MD_LAT-2 cycles (leave when the count is about to reach zero), DONE is
  // the last. With MD_LAT=2 there is no BUSY phase at all.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      MD_IDLE: begin
        if (mdstart_exe) begin
          cnt_load  = 1'b1;
          state_nxt = (MD_LAT == 2) ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        cnt_dec = 1'b1;
        if (cnt_zero || (cnt == MD_CNT_W'(1))) state_nxt = MD_DONE;
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  assign md_stall  = (state == MD_BUSY);
  assign md_active = (state == MD_BUSY) || (state == MD_DONE);
  assign md_last   = (state == MD_DONE);
`else
  logic unused_md;
  assign unused_md = mdstart_exe;
  assign md_stall  = 1'b0;
  assign md_active = 1'b0;
  assign md_last   = 1'b0;
`endif

  logic src_exe_dep, src_mem_dep, lu_hazard, br_hazard, hz_stall;

  assign src_exe_dep = reg_match(writereg_exe, Rs_decode) || reg_match(writereg_exe, Rt_decode);
  assign src_mem_dep = reg_match(writereg_mem, Rs_decode) || reg_match(writereg_mem, Rt_decode);
  assign lu_hazard   = regwrite_exe && memtoreg_exe && src_exe_dep;
  assign br_hazard   = branch_decode && ((regwrite_exe && src_exe_dep) || (memtoreg_mem && src_mem_dep));
  assign hz_stall    = lu_hazard || br_hazard;

  // Output decode; everything is held at zero while reset is asserted.
  // A mul/div stall freezes EXE and ID, so it suppresses both flushes.
  always_comb begin
    stall_fetch     = 1'b0;
    stall_decode    = 1'b0;
    stall_exe       = 1'b0;
    flush_decode    = 1'b0;
    flush_exe       = 1'b0;
    flush_mem       = 1'b0;
    forwardA_exe    = FWD_NONE;
    forwardB_exe    = FWD_NONE;
    forwardA_decode = 1'b0;
    forwardB_decode = 1'b0;
    md_busy         = 1'b0;
    md_done         = 1'b0;
    if (!rst) begin
      stall_fetch  = hz_stall || md_stall;
      stall_decode = hz_stall || md_stall;
      stall_exe    = md_stall;
      flush_mem    = md_stall;
      flush_exe    = hz_stall && !md_stall;
      flush_decode = taken_decode && !(hz_stall || md_stall);
      if (regwrite_mem && reg_match(writereg_mem, Rs_exe))     forwardA_exe = FWD_MEM;
      else if (regwrite_wb && reg_match(writereg_wb, Rs_exe))  forwardA_exe = FWD_WB;
      if (regwrite_mem && reg_match(writereg_mem, Rt_exe))     forwardB_exe = FWD_MEM;
      else if (regwrite_wb && reg_match(writereg_wb, Rt_exe))  forwardB_exe = FWD_WB;
      forwardA_decode = regwrite_mem && !memtoreg_mem && reg_match(writereg_mem, Rs_decode);
      forwardB_decode = regwrite_mem && !memtoreg_mem && reg_match(writereg_mem, Rt_decode);
      md_busy = md_active;
      md_done = md_last;
    end
  end

endmodule
